// File: rtl/pass_seq_check.sv
// rtl/pass_seq_check.sv - multi-digit keypad password checker with set mode and failure lockout
//
// Collects DIGITS keypad digits and compares them against the stored password
// on enter. While open, the password can be changed through set mode.
// Optional feature macro: PASS_LOCKOUT_EN. When defined, MAX_FAIL consecutive
// rejections lock entry out for LOCK_CYC cycles. When undefined, fail_cnt
// saturates and locked_out stays 0.
//
// Ports:
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   mode               0 = check, 1 = set new password (honoured while open)
//   mode_def           checker enable for digit/enter input in idle/entry
//   digit_vld, digit   keypad digit strobe and value
//   enter              submit strobe
//   lock_rst           relock / discard current entry
//   unlocked           lock open (open and set states)
//   fail               one-cycle pulse per rejected entry
//   locked_out         lockout active
//   fail_cnt           consecutive failure count
//   led                status LEDs: idle 000, entry 001, open 110, set 011, lockout 100
module pass_seq_check #(
  parameter int DIGITS = 4,
  parameter int DW = 4,
  parameter logic [DIGITS*DW-1:0] DEF_PASS = 16'h1234,
  parameter int MAX_FAIL = 3,
  parameter int LOCK_CYC = 1000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          mode,
  input  logic                          mode_def,
  input  logic                          digit_vld,
  input  logic [DW-1:0]                 digit,
  input  logic                          enter,
  input  logic                          lock_rst,
  output logic                          unlocked,
  output logic                          fail,
  output logic                          locked_out,
  output logic [$clog2(MAX_FAIL+1)-1:0] fail_cnt,
  output logic [2:0]                    led
);

  localparam int PW  = DIGITS * DW;
  localparam int CW  = $clog2(DIGITS + 1);
  localparam int FCW = $clog2(MAX_FAIL + 1);
  localparam int TW  = (LOCK_CYC > 1) ? $clog2(LOCK_CYC) : 1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ENTRY    = 3'd1,
    UNLOCKED = 3'd2,
    SET      = 3'd3,
    LOCKOUT  = 3'd4
  } state_t;

  state_t          state;
  logic [PW-1:0]   pass;
  logic [PW-1:0]   entry_buf;
  logic [CW-1:0]   cnt;
  logic            ovf;
  logic [TW-1:0]   timer;

  logic [PW-1:0]   shifted;
  logic            full_ok;
  logic [FCW-1:0]  fail_cnt_inc;
  logic            fail_hit;

  // Registered output pattern {unlocked, locked_out, led} for the state being entered.
  function automatic logic [4:0] outs_of(state_t s);
    logic [4:0] o;
    o = 5'b0;
    case (s)
      ENTRY:    o = 5'b0_0_001;
      UNLOCKED: o = 5'b1_0_110;
      SET:      o = 5'b1_0_011;
`ifdef PASS_LOCKOUT_EN
      LOCKOUT:  o = 5'b0_1_100;
`else
      LOCKOUT:  o = 5'b0_0_100;
`endif
      default:  o = 5'b0;
    endcase
    return o;
  endfunction

  always_comb begin
    shifted = (entry_buf << DW) | PW'(digit);
    // Exactly DIGITS digits and none dropped past the end of the buffer.
    full_ok = (cnt == CW'(DIGITS)) && !ovf;
`ifdef PASS_LOCKOUT_EN
    fail_cnt_inc = fail_cnt + FCW'(1);
    fail_hit     = (fail_cnt_inc == FCW'(MAX_FAIL));
`else
    fail_cnt_inc = (fail_cnt == '1) ? fail_cnt : fail_cnt + FCW'(1);
    fail_hit     = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                       <= IDLE;
      pass                        <= DEF_PASS;
      entry_buf                   <= '0;
      cnt                         <= '0;
      ovf                         <= 1'b0;
      timer                       <= '0;
      fail_cnt                    <= '0;
      fail                        <= 1'b0;
      {unlocked, locked_out, led} <= 5'b0;
    end else begin
      fail <= 1'b0;
      case (state)
        IDLE: begin
          // enter and lock_rst both take precedence over a digit in the same cycle.
          if (mode_def && digit_vld && !enter && !lock_rst && !mode) begin
            entry_buf                   <= PW'(digit);
            cnt                         <= CW'(1);
            state                       <= ENTRY;
            {unlocked, locked_out, led} <= outs_of(ENTRY);
          end
        end

        ENTRY: begin
          if (lock_rst || !mode_def) begin
            entry_buf                   <= '0;
            cnt                         <= '0;
            ovf                         <= 1'b0;
            state                       <= IDLE;
            {unlocked, locked_out, led} <= outs_of(IDLE);
          end else if (enter) begin
            entry_buf <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            if (full_ok && entry_buf == pass) begin
              fail_cnt                    <= '0;
              state                       <= UNLOCKED;
              {unlocked, locked_out, led} <= outs_of(UNLOCKED);
            end else begin
              fail     <= 1'b1;
              fail_cnt <= fail_cnt_inc;
              if (fail_hit) begin
                timer                       <= '0;
                state                       <= LOCKOUT;
                {unlocked, locked_out, led} <= outs_of(LOCKOUT);
              end else begin
                state                       <= IDLE;
                {unlocked, locked_out, led} <= outs_of(IDLE);
              end
            end
          end else if (digit_vld) begin
            entry_buf <= shifted;
            if (cnt == CW'(DIGITS)) ovf <= 1'b1;
            else                    cnt <= cnt + CW'(1);
          end
        end

        UNLOCKED: begin
          if (lock_rst) begin
            state                       <= IDLE;
            {unlocked, locked_out, led} <= outs_of(IDLE);
          end else if (digit_vld && mode && !enter) begin
            entry_buf                   <= PW'(digit);
            cnt                         <= CW'(1);
            state                       <= SET;
            {unlocked, locked_out, led} <= outs_of(SET);
          end
        end

        SET: begin
          if (lock_rst) begin
            entry_buf                   <= '0;
            cnt                         <= '0;
            ovf                         <= 1'b0;
            state                       <= IDLE;
            {unlocked, locked_out, led} <= outs_of(IDLE);
          end else if (!mode || enter) begin
            // Leaving set mode; only a complete enter commits the new password.
            if (mode && full_ok) pass <= entry_buf;
            entry_buf                   <= '0;
            cnt                         <= '0;
            ovf                         <= 1'b0;
            state                       <= UNLOCKED;
            {unlocked, locked_out, led} <= outs_of(UNLOCKED);
          end else if (digit_vld) begin
            entry_buf <= shifted;
            if (cnt == CW'(DIGITS)) ovf <= 1'b1;
            else                    cnt <= cnt + CW'(1);
          end
        end

        LOCKOUT: begin
          // Every input, lock_rst included, is ignored until the timer expires.
          if (timer == TW'(LOCK_CYC - 1)) begin
            timer                       <= '0;
            fail_cnt                    <= '0;
            state                       <= IDLE;
            {unlocked, locked_out, led} <= outs_of(IDLE);
          end else begin
            timer <= timer + TW'(1);
          end
        end

        default: begin
          state                       <= IDLE;
          {unlocked, locked_out, led} <= outs_of(IDLE);
        end
      endcase
    end
  end

endmodule
